// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: buffer state encoding,
// entry field widths and the bit order of the stored flag vector.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    localparam int OP_W   = 2;
    localparam int FLAG_W = 4;
    localparam int CNT_W  = 8;

    // Flag vector layout {DIS,P,N,Z}
    localparam int FLAG_Z   = 0;
    localparam int FLAG_N   = 1;
    localparam int FLAG_P   = 2;
    localparam int FLAG_DIS = 3;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flags for a mux result, evaluated on the capture
// path so they are stored alongside the data they describe.
module alu_flag_gen #(
    parameter int W = 8
) (
    input  logic [W-1:0] y_i,
    input  logic         n_en_i,
    output logic         z_o,
    output logic         n_o,
    output logic         p_o,
    output logic         dis_o
);

    assign z_o   = ~|y_i;
    assign n_o   = y_i[W-1];
    assign p_o   = ^y_i;
    assign dis_o = ~n_en_i;

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU result mux: two-entry skid buffer
// (main drives the outputs, skid absorbs one stall) plus a delivery counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [W-1:0]     Y,
    input  logic [OP_W-1:0]  S,
    input  logic             nEN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [W-1:0]     R,
    output logic [OP_W-1:0]  OP,
    output logic             Z,
    output logic             N,
    output logic             P,
    output logic             DIS,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] CNT,
    output logic [1:0]       DBG_STATE
);

    // Handshake: a beat transfers on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a source holding valid keeps
    // its payload unchanged until the transfer happens.

    state_e state_q, state_d;
    logic   ready_q, ready_d;
    logic   acc, dlv;
    logic   out_valid;
    logic   load_main_in, load_main_skid, load_skid;

    logic              fz, fn, fp, fdis;
    logic [FLAG_W-1:0] in_flags;

    logic [W-1:0]      main_y_q, skid_y_q;
    logic [OP_W-1:0]   main_op_q, skid_op_q;
    logic [FLAG_W-1:0] main_flags_q, skid_flags_q;
    logic [CNT_W-1:0]  cnt_q;

    alu_flag_gen #(.W(W)) u_flag_gen (
        .y_i    (Y),
        .n_en_i (nEN),
        .z_o    (fz),
        .n_o    (fn),
        .p_o    (fp),
        .dis_o  (fdis)
    );

    assign in_flags = {fdis, fp, fn, fz};
    assign acc      = IN_VALID & ready_q;
    assign dlv      = out_valid & OUT_READY;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = ST_EMPTY;
        case (state_q)
            ST_EMPTY: state_d = acc ? ST_BUSY : ST_EMPTY;
            ST_BUSY: begin
                if (acc && !dlv)      state_d = ST_FULL;
                else if (dlv && !acc) state_d = ST_EMPTY;
                else                  state_d = ST_BUSY;
            end
            ST_FULL:  state_d = dlv ? ST_BUSY : ST_FULL;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid      = (state_q == ST_BUSY) || (state_q == ST_FULL);
        ready_d        = (state_d != ST_FULL);
        load_main_in   = acc && ((state_q == ST_EMPTY) || ((state_q == ST_BUSY) && dlv));
        load_main_skid = (state_q == ST_FULL) && dlv;
        load_skid      = (state_q == ST_BUSY) && acc && !dlv;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_y_q     <= '0;
            main_op_q    <= '0;
            main_flags_q <= '0;
            skid_y_q     <= '0;
            skid_op_q    <= '0;
            skid_flags_q <= '0;
        end else begin
            if (load_main_in) begin
                main_y_q     <= Y;
                main_op_q    <= S;
                main_flags_q <= in_flags;
            end else if (load_main_skid) begin
                main_y_q     <= skid_y_q;
                main_op_q    <= skid_op_q;
                main_flags_q <= skid_flags_q;
            end
            if (load_skid) begin
                skid_y_q     <= Y;
                skid_op_q    <= S;
                skid_flags_q <= in_flags;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else if (dlv) cnt_q <= cnt_q + 1'b1;
    end

    assign IN_READY  = ready_q;
    assign OUT_VALID = out_valid;
    assign R         = main_y_q;
    assign OP        = main_op_q;
    assign Z         = main_flags_q[FLAG_Z];
    assign N         = main_flags_q[FLAG_N];
    assign P         = main_flags_q[FLAG_P];
    assign DIS       = main_flags_q[FLAG_DIS];
    assign CNT       = cnt_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: single transfer, backpressure,
// streaming, disabled mux, reset while full and counter wrap.
module tb_alu_result_stage;

  logic       clk;
  logic       n_rst;
  logic [7:0] y;
  logic [1:0] s;
  logic       n_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r;
  logic [1:0] op;
  logic       z, n, p, dis;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] cnt;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt;

  alu_result_stage #(.W(8)) dut (
    .CLK       (clk),
    .nRST      (n_rst),
    .Y         (y),
    .S         (s),
    .nEN       (n_en),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .R         (r),
    .OP        (op),
    .Z         (z),
    .N         (n),
    .P         (p),
    .DIS       (dis),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .CNT       (cnt),
    .DBG_STATE (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] dy, input logic [1:0] ds, input logic den);
    y = dy;
    s = ds;
    n_en = den;
    in_valid = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] er, input logic [1:0] eop,
                         input logic ez, input logic en, input logic ep, input logic edis);
    chk({tag, "_r"},   32'(r),   32'(er));
    chk({tag, "_op"},  32'(op),  32'(eop));
    chk({tag, "_z"},   32'(z),   32'(ez));
    chk({tag, "_n"},   32'(n),   32'(en));
    chk({tag, "_p"},   32'(p),   32'(ep));
    chk({tag, "_dis"}, 32'(dis), 32'(edis));
  endtask

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    y = 8'h00; s = 2'b00; n_en = 1'b1;
    exp_cnt = 8'd0;
    step(); step();
    chk_out("por", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("por_ov", 32'(out_valid), 32'd0);
    chk("por_cnt", 32'(cnt), 32'd0);
    n_rst = 1'b1;
    step();
    chk("por_ir", 32'(in_ready), 32'd1);

    // single transfer
    out_ready = 1'b1;
    drive(8'h80, 2'b01, 1'b1);
    step();
    in_valid = 1'b0;
    chk_out("single", 8'h80, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("single_ov", 32'(out_valid), 32'd1);
    step();
    exp_cnt++;
    chk("single_cnt", 32'(cnt), 32'(exp_cnt));
    chk("single_ov_off", 32'(out_valid), 32'd0);

    // backpressure
    out_ready = 1'b0;
    drive(8'h00, 2'b00, 1'b1);
    step();
    chk("bp_ir1", 32'(in_ready), 32'd1);
    drive(8'h03, 2'b10, 1'b1);
    step();
    chk("bp_ir2", 32'(in_ready), 32'd0);
    drive(8'h55, 2'b01, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_ir", 32'(in_ready), 32'd0);
      chk("bp_hold_ov", 32'(out_valid), 32'd1);
      chk_out("bp_hold", 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    step();
    exp_cnt++;
    chk_out("bp_d2", 8'h03, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_d2_ir", 32'(in_ready), 32'd1);
    chk("bp_d2_cnt", 32'(cnt), 32'(exp_cnt));
    step();
    exp_cnt++;
    in_valid = 1'b0;
    chk_out("bp_d3", 8'h55, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_d3_ov", 32'(out_valid), 32'd1);
    step();
    exp_cnt++;
    chk("bp_end_ov", 32'(out_valid), 32'd0);
    chk("bp_end_cnt", 32'(cnt), 32'(exp_cnt));

    // streaming, latency 1
    drive(8'h01, 2'b00, 1'b1); step();
    chk("st0_r", 32'(r), 32'h01); chk("st0_ir", 32'(in_ready), 32'd1);
    drive(8'h02, 2'b00, 1'b1); step(); exp_cnt++;
    chk("st1_r", 32'(r), 32'h02); chk("st1_ir", 32'(in_ready), 32'd1);
    drive(8'h04, 2'b00, 1'b1); step(); exp_cnt++;
    chk("st2_r", 32'(r), 32'h04); chk("st2_ir", 32'(in_ready), 32'd1);
    drive(8'h08, 2'b00, 1'b1); step(); exp_cnt++;
    chk("st3_r", 32'(r), 32'h08); chk("st3_ov", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step(); exp_cnt++;
    chk("st_cnt", 32'(cnt), 32'(exp_cnt));
    chk("st_cnt_abs", 32'(cnt), 32'd8);

    // disabled mux
    drive(8'h00, 2'b11, 1'b0);
    step();
    in_valid = 1'b0;
    n_en = 1'b1;
    chk_out("dis", 8'h00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); exp_cnt++;
    chk("dis_cnt", 32'(cnt), 32'(exp_cnt));

    // reset while FULL, asserted mid-cycle
    out_ready = 1'b0;
    drive(8'hA5, 2'b01, 1'b1); step();
    drive(8'h7E, 2'b10, 1'b1); step();
    chk("rst_pre_full", 32'(dbg_state), 32'd2);
    in_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    chk_out("rst", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    step();
    n_rst = 1'b1;
    step();
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_ov2", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    chk("rst_skid_gone", 32'(out_valid), 32'd0);
    chk("rst_cnt2", 32'(cnt), 32'd0);

    // counter wrap: 256 streamed results
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      drive(8'(i), 2'b01, 1'b1);
      step();
      chk("wrap_r", 32'(r), 32'(i));
      chk("wrap_cnt", 32'(cnt), 32'(exp_cnt));
      exp_cnt++;
    end
    chk("wrap_255", 32'(cnt), 32'd255);
    in_valid = 1'b0;
    step();
    chk("wrap_0", 32'(cnt), 32'd0);
    chk("wrap_ov", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
